// File: rtl/cm0_fetch_unit_if.sv
// cm0_fetch_unit_if: instruction-bus, redirect and decode-handshake signals of the fetch unit
interface cm0_fetch_unit_if #(parameter int BW = 32);
    logic          ibus_req;
    logic [BW-1:0] ibus_addr;
    logic          ibus_gnt;
    logic          ibus_rvalid;
    logic [BW-1:0] ibus_rdata;
    logic          branch_valid;
    logic [BW-1:0] branch_target;
    logic          instr_valid;
    logic [15:0]   instr_data;
    logic [BW-1:0] instr_pc;
    logic          instr_ready;
    modport master (
        output ibus_req, ibus_addr, instr_valid, instr_data, instr_pc,
        input  ibus_gnt, ibus_rvalid, ibus_rdata, branch_valid, branch_target, instr_ready
    );
    modport slave (
        input  ibus_req, ibus_addr, instr_valid, instr_data, instr_pc,
        output ibus_gnt, ibus_rvalid, ibus_rdata, branch_valid, branch_target, instr_ready
    );
endinterface

// File: rtl/cm0_fetch_unit.sv
// cm0_fetch_unit: Thumb prefetch stage, word fetches split into a 4-entry halfword FIFO with branch flush
module cm0_fetch_unit #(
    parameter int            BW       = 32,
    parameter logic [BW-1:0] RESET_PC = '0
) (
    input logic               clk,
    input logic               reset,
    cm0_fetch_unit_if.master  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, WAIT_DISCARD} state_t;
    state_t        state;
    logic [BW-1:0] fetch_addr;
    logic [BW-1:0] pend_addr;
    logic          skip_low;
    logic [15:0]   hw_q [4];
    logic [BW-1:0] pc_q [4];
    logic [1:0]    rd_ptr;
    logic [1:0]    wr_ptr;
    logic [2:0]    count;
    logic          pop;
    logic          take;
    logic [2:0]    n_push;
    // Request only when the FIFO can absorb a full word, so count never exceeds 4
    assign bus.ibus_req    = !reset && state == IDLE && count <= 3'd2 && !bus.branch_valid;
    assign bus.ibus_addr   = fetch_addr;
    assign bus.instr_valid = count != 3'd0;
    assign bus.instr_data  = bus.instr_valid ? hw_q[rd_ptr] : '0;
    assign bus.instr_pc    = bus.instr_valid ? pc_q[rd_ptr] : '0;
    assign pop    = bus.instr_valid && bus.instr_ready;
    assign take   = state == WAIT && bus.ibus_rvalid;
    assign n_push = take ? (skip_low ? 3'd1 : 3'd2) : 3'd0;
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fetch_addr <= {RESET_PC[BW-1:2], 2'b00};
            skip_low   <= RESET_PC[1];
            pend_addr  <= '0;
        end else if (bus.branch_valid) begin
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fetch_addr <= {bus.branch_target[BW-1:2], 2'b00};
            skip_low   <= bus.branch_target[1];
            state      <= (state == IDLE || bus.ibus_rvalid) ? IDLE : WAIT_DISCARD;
        end else begin
            count  <= count + n_push - {2'b00, pop};
            rd_ptr <= rd_ptr + {1'b0, pop};
            wr_ptr <= wr_ptr + n_push[1:0];
            if (take) begin
                hw_q[wr_ptr] <= skip_low ? bus.ibus_rdata[31:16] : bus.ibus_rdata[15:0];
                pc_q[wr_ptr] <= skip_low ? pend_addr + BW'(2) : pend_addr;
                if (!skip_low) begin
                    hw_q[wr_ptr + 2'd1] <= bus.ibus_rdata[31:16];
                    pc_q[wr_ptr + 2'd1] <= pend_addr + BW'(2);
                end
            end
            case (state)
                IDLE: if (bus.ibus_req && bus.ibus_gnt) begin
                    pend_addr  <= fetch_addr;
                    fetch_addr <= fetch_addr + BW'(4);
                    state      <= WAIT;
                end
                WAIT: if (bus.ibus_rvalid) begin
                    skip_low <= 1'b0;
                    state    <= IDLE;
                end
                WAIT_DISCARD: if (bus.ibus_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cm0_fetch_unit.sv
// tb_cm0_fetch_unit: directed scenarios then random traffic against a queue-based fetch model
module tb_cm0_fetch_unit;
    localparam logic [31:0] RPC = 32'h0000_0100;
    typedef struct {logic [15:0] hw; logic [31:0] pc;} ent_t;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    cm0_fetch_unit_if #(.BW(32)) bus();
    cm0_fetch_unit #(.BW(32), .RESET_PC(RPC)) dut (.clk(clk), .reset(reset), .bus(bus));
    int tests = 0;
    int fails = 0;
    ent_t        q[$];
    logic [31:0] m_addr;
    logic [31:0] m_paddr;
    logic        m_skip;
    int          m_out;
    logic        exp_req;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic setin(input logic rs, input logic g, input logic rv, input logic [31:0] rd,
                         input logic br, input logic [31:0] bt, input logic rdy);
        reset = rs;
        bus.ibus_gnt = g;
        bus.ibus_rvalid = rv;
        bus.ibus_rdata = rd;
        bus.branch_valid = br;
        bus.branch_target = bt;
        bus.instr_ready = rdy;
        #1;
        exp_req = !rs && m_out == 0 && q.size() <= 2 && !br;
        chk("ibus_req", bus.ibus_req, exp_req);
        if (exp_req) chk("ibus_addr", bus.ibus_addr, m_addr);
        chk("instr_valid", bus.instr_valid, q.size() != 0);
        chk("instr_data", bus.instr_data, q.size() != 0 ? q[0].hw : 16'h0);
        chk("instr_pc", bus.instr_pc, q.size() != 0 ? q[0].pc : 32'h0);
    endtask
    // m_out: 0 = nothing outstanding, 1 = live fetch, 2 = fetch to be discarded
    task automatic adv();
        if (reset) begin
            q.delete();
            m_addr = RPC & ~32'h3;
            m_skip = (RPC & 32'h2) != 0;
            m_out = 0;
        end else if (bus.branch_valid) begin
            q.delete();
            m_addr = bus.branch_target & ~32'h3;
            m_skip = (bus.branch_target & 32'h2) != 0;
            m_out = (m_out != 0 && !bus.ibus_rvalid) ? 2 : 0;
        end else begin
            if (q.size() != 0 && bus.instr_ready) void'(q.pop_front());
            if (m_out == 0) begin
                if (exp_req && bus.ibus_gnt) begin
                    m_paddr = m_addr;
                    m_addr = m_addr + 32'd4;
                    m_out = 1;
                end
            end else if (bus.ibus_rvalid) begin
                if (m_out == 1) begin
                    if (!m_skip) q.push_back('{bus.ibus_rdata[15:0], m_paddr});
                    q.push_back('{bus.ibus_rdata[31:16], m_paddr + 32'd2});
                    m_skip = 1'b0;
                end
                m_out = 0;
            end
        end
        @(negedge clk);
    endtask
    initial begin
        logic rs, br, rv;
        reset = 1'b1;
        bus.ibus_gnt = 0; bus.ibus_rvalid = 0; bus.ibus_rdata = 0;
        bus.branch_valid = 0; bus.branch_target = 0; bus.instr_ready = 0;
        m_addr = RPC & ~32'h3; m_skip = (RPC & 32'h2) != 0; m_out = 0; m_paddr = 0;
        repeat (2) @(negedge clk);
        setin(1, 0, 0, 0, 0, 0, 0); adv();
        // Basic fetch from the reset PC
        setin(0, 1, 0, 0, 0, 0, 1);
        chk("t1 req", bus.ibus_req, 1); chk("t1 addr", bus.ibus_addr, 32'h100); adv();
        setin(0, 0, 1, 32'hBBBBAAAA, 0, 0, 1); adv();
        setin(0, 0, 0, 0, 0, 0, 1);
        chk("t1 hw0", bus.instr_data, 16'hAAAA); chk("t1 pc0", bus.instr_pc, 32'h100); adv();
        setin(0, 1, 0, 0, 0, 0, 1);
        chk("t1 hw1", bus.instr_data, 16'hBBBB); chk("t1 pc1", bus.instr_pc, 32'h102);
        chk("t1 next addr", bus.ibus_addr, 32'h104); adv();
        // FIFO fill and request throttling
        setin(0, 0, 1, 32'h22221111, 0, 0, 0); adv();
        setin(0, 1, 0, 0, 0, 0, 0); chk("t2 req c2", bus.ibus_req, 1); adv();
        setin(0, 0, 1, 32'h44443333, 0, 0, 0); adv();
        setin(0, 1, 0, 0, 0, 0, 1);
        chk("t2 req c4", bus.ibus_req, 0); chk("t2 head", bus.instr_data, 16'h1111);
        chk("t2 head pc", bus.instr_pc, 32'h104); adv();
        setin(0, 1, 0, 0, 0, 0, 1); chk("t2 req c3", bus.ibus_req, 0); adv();
        setin(0, 0, 0, 0, 0, 0, 0); chk("t2 req back c2", bus.ibus_req, 1); adv();
        // Branch to an odd-halfword target
        setin(0, 0, 0, 0, 1, 32'h203, 1); chk("t3 req in branch", bus.ibus_req, 0); adv();
        setin(0, 1, 0, 0, 0, 0, 1);
        chk("t3 flushed", bus.instr_valid, 0); chk("t3 addr", bus.ibus_addr, 32'h200); adv();
        setin(0, 0, 1, 32'hDDDDCCCC, 0, 0, 1); adv();
        setin(0, 1, 0, 0, 0, 0, 1);
        chk("t3 hw", bus.instr_data, 16'hDDDD); chk("t3 pc", bus.instr_pc, 32'h202); adv();
        // Branch while a fetch is in flight
        setin(0, 0, 0, 0, 1, 32'h400, 0); adv();
        setin(0, 0, 0, 0, 0, 0, 0); adv();
        setin(0, 0, 0, 0, 0, 0, 0); adv();
        setin(0, 1, 1, 32'h11112222, 0, 0, 0); chk("t4 req discard", bus.ibus_req, 0); adv();
        setin(0, 1, 0, 0, 0, 0, 0);
        chk("t4 dropped", bus.instr_valid, 0); chk("t4 addr", bus.ibus_addr, 32'h400); adv();
        // Branch, rvalid and ready in the same cycle
        setin(0, 0, 1, 32'h66665555, 0, 0, 0); adv();
        setin(0, 1, 0, 0, 0, 0, 0); chk("t5 addr", bus.ibus_addr, 32'h404); adv();
        setin(0, 0, 1, 32'h77777777, 1, 32'h500, 1); chk("t5 head", bus.instr_data, 16'h5555); adv();
        setin(0, 0, 0, 0, 0, 0, 0);
        chk("t5 empty", bus.instr_valid, 0); chk("t5 idle req", bus.ibus_req, 1);
        chk("t5 addr", bus.ibus_addr, 32'h500); adv();
        // Address wrap and reset with a late response
        setin(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0); adv();
        setin(0, 1, 0, 0, 0, 0, 0); chk("t6 addr", bus.ibus_addr, 32'hFFFF_FFFC); adv();
        setin(0, 0, 1, 32'h87654321, 0, 0, 0); adv();
        setin(0, 0, 0, 0, 0, 0, 1);
        chk("t6 hw0", bus.instr_data, 16'h4321); chk("t6 pc0", bus.instr_pc, 32'hFFFF_FFFC); adv();
        setin(0, 1, 0, 0, 0, 0, 1);
        chk("t6 hw1", bus.instr_data, 16'h8765); chk("t6 pc1", bus.instr_pc, 32'hFFFF_FFFE);
        chk("t6 wrap", bus.ibus_addr, 32'h0); adv();
        setin(1, 0, 0, 0, 0, 0, 0); adv();
        setin(0, 0, 1, 32'hCAFEBABE, 0, 0, 0); adv();
        setin(0, 0, 0, 0, 0, 0, 0); chk("t6 late rvalid", bus.instr_valid, 0); adv();
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom % 150) == 0;
            br = ($urandom % 12) == 0;
            rv = (m_out != 0) ? (($urandom % 3) == 0) : (($urandom % 10) == 0);
            setin(rs, 1'($urandom % 2), rv, $urandom, br, $urandom, 1'(($urandom % 4) != 0));
            adv();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
